pcr_file_trap: RTL and testbench

//  Next-generation processor control register (PCR) file, parametrised in XLEN and external interrupt count.

---
 rtl/pcr_file_trap.sv | 196 +++++++++++++++++++
 tb/tb_pcr_file_trap.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcr_file_trap.sv
// Processor control register file with a free-running timer, interrupt masking,
// trap entry/ERET sequencing and a host-side FROMHOST write port.
module pcr_file_trap #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               enable,
  input  logic [1:0]         cmd,
  input  logic [4:0]         pcr,
  input  logic [11:0]        imm12,
  input  logic [XLEN-1:0]    wdata,
  output logic [XLEN-1:0]    rdata,
  input  logic               exception,
  input  logic [4:0]         exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic               exc_bad_valid,
  input  logic [XLEN-1:0]    exc_badvaddr,
  input  logic               eret,
  input  logic [NUM_IRQ-1:0] ext_irq,
  input  logic               host_wr,
  input  logic [XLEN-1:0]    host_wdata,
  output logic               irq_take,
  output logic [4:0]         irq_cause,
  output logic [XLEN-1:0]    status,
  output logic [XLEN-1:0]    evec,
  output logic [XLEN-1:0]    epc,
  output logic [XLEN-1:0]    tohost
);

  typedef enum logic [1:0] {
    CMD_MFPCR    = 2'd0,
    CMD_MTPCR    = 2'd1,
    CMD_SETPCR   = 2'd2,
    CMD_CLEARPCR = 2'd3
  } cmd_e;

  localparam logic [4:0] PCR_STATUS   = 5'd0;
  localparam logic [4:0] PCR_EPC      = 5'd1;
  localparam logic [4:0] PCR_BADVADDR = 5'd2;
  localparam logic [4:0] PCR_EVEC     = 5'd3;
  localparam logic [4:0] PCR_COUNT    = 5'd4;
  localparam logic [4:0] PCR_COMPARE  = 5'd5;
  localparam logic [4:0] PCR_CAUSE    = 5'd6;
  localparam logic [4:0] PCR_PTBR     = 5'd7;
  localparam logic [4:0] PCR_K0       = 5'd12;
  localparam logic [4:0] PCR_K1       = 5'd13;
  localparam logic [4:0] PCR_TOHOST   = 5'd30;
  localparam logic [4:0] PCR_FROMHOST = 5'd31;

  logic            r_et, r_ps, r_s, r_vm, r_tp;
  logic [7:0]      r_im;
  logic [XLEN-1:0] r_epc, r_badvaddr, r_evec, r_count, r_compare, r_cause;
  logic [XLEN-1:0] r_ptbr, r_k0, r_k1, r_tohost, r_fromhost;

  cmd_e            w_cmd;
  logic [7:0]      w_ip, w_pend;
  logic [XLEN-1:0] w_status, w_old, w_sext, w_wval, w_count_next, w_trap_cause;
  logic            w_trap, w_eret, w_core_wr, w_wr_count, w_wr_compare, w_tp_next;

  assign w_cmd  = cmd_e'(cmd);
  assign w_ip   = {r_tp, 7'(ext_irq)};
  assign w_sext = {{(XLEN-12){imm12[11]}}, imm12};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_status        = '0;
    w_status[0]     = r_et;
    w_status[4]     = r_ps;
    w_status[5]     = r_s;
    w_status[8]     = r_vm;
    w_status[23:16] = w_ip;
    w_status[31:24] = r_im;
  end

  always_comb begin
    w_old = '0;
    case (pcr)
      PCR_STATUS:   w_old = w_status;
      PCR_EPC:      w_old = r_epc;
      PCR_BADVADDR: w_old = r_badvaddr;
      PCR_EVEC:     w_old = r_evec;
      PCR_COUNT:    w_old = r_count;
      PCR_COMPARE:  w_old = r_compare;
      PCR_CAUSE:    w_old = r_cause;
      PCR_PTBR:     w_old = r_ptbr;
      PCR_K0:       w_old = r_k0;
      PCR_K1:       w_old = r_k1;
      PCR_TOHOST:   w_old = r_tohost;
      PCR_FROMHOST: w_old = r_fromhost;
      default:      w_old = '0;
    endcase
  end

  always_comb begin
    w_wval = w_old;
    case (w_cmd)
      CMD_MTPCR:    w_wval = wdata;
      CMD_SETPCR:   w_wval = w_old | w_sext;
      CMD_CLEARPCR: w_wval = w_old & ~w_sext;
      default:      w_wval = w_old;
    endcase
  end

  // Trap beats ERET beats software writes; stall freezes all three.
  assign w_trap       = exception & ~stall;
  assign w_eret       = eret & ~exception & ~stall;
  assign w_core_wr    = enable & (w_cmd != CMD_MFPCR) & ~stall & ~exception & ~eret;
  assign w_wr_count   = w_core_wr & (pcr == PCR_COUNT);
  assign w_wr_compare = w_core_wr & (pcr == PCR_COMPARE);

  assign w_count_next = w_wr_count ? w_wval : r_count + XLEN'(1);
  assign w_tp_next    = w_wr_compare ? 1'b0 :
                        (w_count_next == r_compare) ? 1'b1 : r_tp;

  always_comb begin
    w_trap_cause         = '0;
    w_trap_cause[XLEN-1] = ~r_et;
    w_trap_cause[4:0]    = exc_cause;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_et       <= 1'b0;
      r_ps       <= 1'b0;
      r_s        <= 1'b1;
      r_vm       <= 1'b0;
      r_im       <= '0;
      r_tp       <= 1'b0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_evec     <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_cause    <= '0;
      r_ptbr     <= '0;
      r_k0       <= '0;
      r_k1       <= '0;
      r_tohost   <= '0;
      r_fromhost <= '0;
    end else begin
      r_count <= w_count_next;
      r_tp    <= w_tp_next;
      if (w_trap) begin
        r_epc   <= exc_pc;
        r_cause <= w_trap_cause;
        if (exc_bad_valid) r_badvaddr <= exc_badvaddr;
        r_ps <= r_s;
        r_s  <= 1'b1;
        r_et <= 1'b0;
      end else if (w_eret) begin
        r_s  <= r_ps;
        r_et <= 1'b1;
      end else if (w_core_wr) begin
        case (pcr)
          PCR_STATUS: begin
            r_et <= w_wval[0];
            r_ps <= w_wval[4];
            r_s  <= w_wval[5];
            r_vm <= w_wval[8];
            r_im <= w_wval[31:24];
          end
          PCR_EVEC:    r_evec    <= {w_wval[XLEN-1:2], 2'b00};
          PCR_COMPARE: r_compare <= w_wval;
          PCR_PTBR:    r_ptbr    <= w_wval;
          PCR_K0:      r_k0      <= w_wval;
          PCR_K1:      r_k1      <= w_wval;
          PCR_TOHOST:  r_tohost  <= w_wval;
          default: ;
        endcase
      end
      // The host port ignores stall and overrides a same-cycle core write.
      if (host_wr) r_fromhost <= host_wdata;
      else if (w_core_wr && (pcr == PCR_FROMHOST)) r_fromhost <= w_wval;
    end
  end

  assign w_pend   = w_ip & r_im;
  assign irq_take = r_et & (|w_pend);

  always_comb begin
    irq_cause = '0;
    for (int i = 7; i >= 0; i--)
      if (w_pend[i]) irq_cause = 5'(16 + i);
  end

  assign rdata  = enable ? w_old : '0;
  assign status = w_status;
  assign evec   = r_evec;
  assign epc    = r_epc;
  assign tohost = r_tohost;

endmodule

// File: tb/tb_pcr_file_trap.sv
// Bench for pcr_file_trap: directed checks with literal expectations, then random
// traffic compared every cycle against an array-based model of the register file.
module tb_pcr_file_trap;
  localparam int XLEN    = 32;
  localparam int NUM_IRQ = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, stall, enable, exc_bad_valid, eret, exception, host_wr;
  logic [1:0]         cmd;
  logic [4:0]         pcr, exc_cause;
  logic [11:0]        imm12;
  logic [XLEN-1:0]    wdata, exc_pc, exc_badvaddr, host_wdata;
  logic [NUM_IRQ-1:0] ext_irq;
  logic [XLEN-1:0]    rdata, status, evec, epc, tohost;
  logic               irq_take;
  logic [4:0]         irq_cause;

  pcr_file_trap #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
    .clk(clk), .reset(reset), .stall(stall), .enable(enable), .cmd(cmd), .pcr(pcr),
    .imm12(imm12), .wdata(wdata), .rdata(rdata), .exception(exception),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_bad_valid(exc_bad_valid),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .ext_irq(ext_irq), .host_wr(host_wr),
    .host_wdata(host_wdata), .irq_take(irq_take), .irq_cause(irq_cause),
    .status(status), .evec(evec), .epc(epc), .tohost(tohost)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: one word per PCR index; STATUS word holds only its writable bits.
  logic [31:0] m [0:31];
  logic        m_tp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mapped(input logic [4:0] idx);
    return idx inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd30, 5'd31};
  endfunction

  function automatic bit sw_writable(input logic [4:0] idx);
    return is_mapped(idx) && !(idx inside {5'd1, 5'd2, 5'd6});
  endfunction

  function automatic logic [7:0] model_ip();
    return {m_tp, ext_irq};
  endfunction

  function automatic logic [31:0] model_status();
    return m[0] | {8'h00, model_ip(), 16'h0000};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (!is_mapped(idx)) return 32'h0;
    if (idx == 5'd0) return model_status();
    return m[idx];
  endfunction

  function automatic logic [4:0] model_cause();
    logic [7:0] p;
    p = model_ip() & m[0][31:24];
    for (int i = 0; i < 8; i++)
      if (p[i]) return 5'(16 + i);
    return 5'd0;
  endfunction

  task automatic model_step();
    logic [31:0] old, sx, v, nc, st;
    bit cmp_wr;
    if (reset) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      m[0] = 32'h20;
      m_tp = 1'b0;
      return;
    end
    old    = model_read(pcr);
    sx     = {{20{imm12[11]}}, imm12};
    nc     = m[4] + 32'd1;
    cmp_wr = 1'b0;
    st     = m[0];
    if (!stall && exception) begin
      m[1] = exc_pc;
      m[6] = {~st[0], 26'b0, exc_cause};
      if (exc_bad_valid) m[2] = exc_badvaddr;
      st[4] = st[5];
      st[5] = 1'b1;
      st[0] = 1'b0;
      m[0]  = st;
    end else if (!stall && eret) begin
      st[5] = st[4];
      st[0] = 1'b1;
      m[0]  = st;
    end else if (!stall && enable && cmd != 2'd0 && sw_writable(pcr)) begin
      case (cmd)
        2'd1:    v = wdata;
        2'd2:    v = old | sx;
        default: v = old & ~sx;
      endcase
      case (pcr)
        5'd0:    m[0] = v & 32'hFF00_0131;
        5'd3:    m[3] = v & ~32'd3;
        5'd4:    nc = v;
        5'd5:    begin m[5] = v; cmp_wr = 1'b1; end
        default: m[pcr] = v;
      endcase
    end
    if (cmp_wr) m_tp = 1'b0;
    else if (nc == m[5]) m_tp = 1'b1;
    m[4] = nc;
    if (host_wr) m[31] = host_wdata;
  endtask

  always @(posedge clk) model_step();

  // Single compare process: every output against the model, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata",     rdata,     enable ? model_read(pcr) : 32'h0);
      check("status",    status,    model_status());
      check("evec",      evec,      m[3]);
      check("epc",       epc,       m[1]);
      check("tohost",    tohost,    m[30]);
      check("irq_take",  32'(irq_take),  32'(m[0][0] && ((model_ip() & m[0][31:24]) != 8'h0)));
      check("irq_cause", 32'(irq_cause), 32'(model_cause()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; enable = 0; cmd = 0; pcr = 0; imm12 = 0; wdata = 0;
    exception = 0; exc_cause = 0; exc_pc = 0; exc_bad_valid = 0; exc_badvaddr = 0;
    eret = 0; ext_irq = 0; host_wr = 0; host_wdata = 0;
  endtask

  task automatic mtpcr(input logic [4:0] idx, input logic [31:0] val);
    enable = 1; cmd = 2'd1; pcr = idx; wdata = val;
    step();
    enable = 0; cmd = 0;
  endtask

  task automatic mfpcr(input logic [4:0] idx);
    enable = 1; cmd = 2'd0; pcr = idx;
  endtask

  logic [4:0] pick [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                            5'd12, 5'd13, 5'd30, 5'd31};

  initial begin
    idle();
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 0;
    chk_en = 1;

    // COUNT reads 0,1,2 from reset; stall has no effect on it.
    stall = 1;
    mfpcr(5'd4);
    @(negedge clk);
    check("count0", rdata, 32'd0);
    check("status_rst", status, 32'h20);
    check("irq_take_rst", 32'(irq_take), 32'd0);
    step(); @(negedge clk); check("count1", rdata, 32'd1);
    step(); @(negedge clk); check("count2", rdata, 32'd2);
    step();
    stall = 0;

    mfpcr(5'd0);
    @(negedge clk); check("mfpcr_status", rdata, 32'h20);
    step();

    // Read-old on write, then masked STATUS.
    enable = 1; cmd = 2'd1; pcr = 5'd0; wdata = 32'hFFFF_FFFF;
    @(negedge clk); check("status_read_old", rdata, 32'h20);
    step();
    mfpcr(5'd0);
    @(negedge clk); check("status_mask", rdata, 32'hFF00_0131);

    enable = 1; cmd = 2'd2; pcr = 5'd3; imm12 = 12'hFFF;
    step();
    idle();
    @(negedge clk); check("evec_set", evec, 32'hFFFF_FFFC);

    // Timer interrupt: ET=1, S=1, IM[7]=1 only.
    mtpcr(5'd0, 32'h8000_0021);
    mtpcr(5'd5, 32'd10);
    mtpcr(5'd4, 32'd0);
    mfpcr(5'd4);
    for (int i = 0; i < 9; i++) step();
    @(negedge clk);
    check("count9", rdata, 32'd9);
    check("irq_before", 32'(irq_take), 32'd0);
    step();
    @(negedge clk);
    check("count10", rdata, 32'd10);
    check("irq_timer", 32'(irq_take), 32'd1);
    check("irq_cause_timer", 32'(irq_cause), 32'h17);
    mtpcr(5'd5, 32'd1000);
    @(negedge clk); check("irq_cleared", 32'(irq_take), 32'd0);

    // Trap entry, nested trap, ERET.
    exception = 1; exc_cause = 5'd5; exc_pc = 32'h100;
    step();
    exception = 0;
    mfpcr(5'd6);
    @(negedge clk);
    check("trap_cause", rdata, 32'd5);
    check("trap_epc", epc, 32'h100);
    check("trap_status", status, 32'h8000_0030);
    exception = 1; exc_pc = 32'h200; exc_bad_valid = 1; exc_badvaddr = 32'hDEAD_0000;
    step();
    exception = 0; exc_bad_valid = 0;
    @(negedge clk); check("nested_cause", rdata, 32'h8000_0005);
    mfpcr(5'd2);
    @(negedge clk); check("badvaddr", rdata, 32'hDEAD_0000);
    eret = 1;
    step();
    eret = 0;
    @(negedge clk); check("eret_status", status, 32'h8000_0031);

    // Exception beats a same-cycle MTPCR.
    mtpcr(5'd12, 32'h11);
    exception = 1; exc_cause = 5'd7; exc_pc = 32'h300;
    enable = 1; cmd = 2'd1; pcr = 5'd12; wdata = 32'h22;
    step();
    exception = 0;
    mfpcr(5'd12);
    @(negedge clk); check("k0_kept", rdata, 32'h11);

    // Stalled exception changes nothing.
    stall = 1; exception = 1; exc_cause = 5'd3; exc_pc = 32'h999;
    exc_bad_valid = 1; exc_badvaddr = 32'h1234;
    step();
    stall = 0; exception = 0; exc_bad_valid = 0;
    mfpcr(5'd6);
    @(negedge clk);
    check("stall_cause", rdata, 32'd7);
    check("stall_epc", epc, 32'h300);

    // Host write wins over core FROMHOST write.
    host_wr = 1; host_wdata = 32'hABCD;
    enable = 1; cmd = 2'd1; pcr = 5'd31; wdata = 32'h1;
    step();
    host_wr = 0;
    mfpcr(5'd31);
    @(negedge clk); check("fromhost", rdata, 32'hABCD);

    // COUNT wrap after software write.
    mtpcr(5'd4, 32'hFFFF_FFFF);
    mfpcr(5'd4);
    @(negedge clk); check("count_max", rdata, 32'hFFFF_FFFF);
    step();
    @(negedge clk); check("count_wrap", rdata, 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 99) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      enable        = 1'($urandom_range(0, 1));
      cmd           = 2'($urandom_range(0, 3));
      pcr           = ($urandom_range(0, 5) == 0) ? 5'($urandom) : pick[$urandom_range(0, 11)];
      imm12         = 12'($urandom);
      wdata         = $urandom;
      if (pcr == 5'd5 && $urandom_range(0, 1) == 1) wdata = m[4] + $urandom_range(1, 20);
      if (pcr == 5'd4 && $urandom_range(0, 3) == 0) wdata = 32'hFFFF_FFFF - $urandom_range(0, 3);
      exception     = ($urandom_range(0, 15) == 0);
      exc_cause     = 5'($urandom);
      exc_pc        = $urandom;
      exc_bad_valid = 1'($urandom_range(0, 1));
      exc_badvaddr  = $urandom;
      eret          = ($urandom_range(0, 15) == 0);
      ext_irq       = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
      host_wr       = ($urandom_range(0, 7) == 0);
      host_wdata    = $urandom;
      step();
    end
    reset = 0;
    idle();
    step();
    @(negedge clk);
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
